// File: rtl/ppi_multiport.sv
// Multi-port 8255-style parallel interface: NPORTS ports, each simple or strobed I/O.
// Build option PPI_FIFO_EN: strobed inputs use a DEPTH-entry FIFO instead of a single latch.

module ppi_port #(
    parameter int DW      = 8,
    parameter int FD      = 1,
    parameter bit RST_DIR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_data,
    input  logic          wr_ctrl,
    input  logic          rd_data,
    input  logic [DW-1:0] cpu_din,
    input  logic [DW-1:0] pin_din,
    input  logic          stb,
    input  logic          ack,
    output logic [DW-1:0] rd_val,
    output logic [DW-1:0] status,
    output logic [DW-1:0] pout,
    output logic          oe,
    output logic          ibf,
    output logic          obf_n,
    output logic          intr
);
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD) + 1;

    logic          dir, mode, inte, overrun;
    logic [DW-1:0] latch;
    logic [DW-1:0] mem [0:(1<<PW)-1];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic          stb_s, stb_d, ack_s, ack_d;
    logic [DW-1:0] din_s;

    logic empty, full, push, pop, ack_rise, flush;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(FD));
    assign push     = mode & dir & stb_s & ~stb_d;
    assign pop      = mode & dir & rd_data & ~empty;
    assign ack_rise = ack_s & ~ack_d;
    // Any change of direction or mode invalidates buffered data and handshake state.
    assign flush    = wr_ctrl & ((cpu_din[0] != dir) | (cpu_din[1] != mode) | cpu_din[3]);

    always_ff @(posedge clk) begin
        if (rst) begin
            dir     <= RST_DIR;
            mode    <= 1'b0;
            inte    <= 1'b0;
            overrun <= 1'b0;
            latch   <= '0;
            obf_n   <= 1'b1;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            stb_s   <= 1'b0;
            stb_d   <= 1'b0;
            ack_s   <= 1'b0;
            ack_d   <= 1'b0;
            din_s   <= '0;
        end else begin
            stb_s <= stb;
            stb_d <= stb_s;
            ack_s <= ack;
            ack_d <= ack_s;
            din_s <= pin_din;
            if (wr_ctrl) begin
                dir  <= cpu_din[0];
                mode <= cpu_din[1];
                inte <= cpu_din[2];
            end
            if (flush) begin
                wptr    <= '0;
                rptr    <= '0;
                cnt     <= '0;
                overrun <= 1'b0;
                obf_n   <= 1'b1;
                latch   <= '0;
            end else begin
                // A pop in the same cycle frees the slot, so a push at full still lands.
                if (push && (!full || pop))
                    wptr <= nxt(wptr);
                if (pop)
                    rptr <= nxt(rptr);
                if (push && !pop && !full)
                    cnt <= cnt + CW'(1);
                else if (pop && !push)
                    cnt <= cnt - CW'(1);
                if (push && full && !pop)
                    overrun <= 1'b1;
                if (wr_data && !dir) begin
                    latch <= cpu_din;
                    if (mode)
                        obf_n <= 1'b0;
                end else if (ack_rise && mode && !dir) begin
                    obf_n <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && push && (!full || pop))
            mem[wptr] <= din_s;
    end

    always_comb begin
        rd_val = '1;
        if (!mode)
            rd_val = dir ? pin_din : latch;
        else if (!dir)
            rd_val = latch;
        else if (!empty)
            rd_val = mem[rptr];
    end

    assign intr = inte & (dir ? ~empty : obf_n);

    // FIFO/handshake flags are only meaningful in strobed mode.
    always_comb begin
        status    = '0;
        status[6] = overrun;
        status[5] = mode & dir & empty;
        status[4] = mode & (dir ? full : ~obf_n);
        status[3] = intr;
        status[2] = inte;
        status[1] = mode;
        status[0] = dir;
    end

    assign pout = latch;
    assign oe   = ~dir;
    assign ibf  = ~empty;
endmodule

module ppi_multiport #(
    parameter int               NPORTS  = 2,
    parameter int               DW      = 8,
    parameter int               DEPTH   = 4,
    parameter logic [NPORTS-1:0] RST_DIR = {NPORTS{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           addr,
    input  logic [DW-1:0]        din,
    output logic [DW-1:0]        dout,
    input  logic                 rdn,
    input  logic                 wrn,
    input  logic                 csn,
    input  logic [NPORTS*DW-1:0] port_din,
    output logic [NPORTS*DW-1:0] port_dout,
    output logic [NPORTS-1:0]    port_oe,
    input  logic [NPORTS-1:0]    stb,
    input  logic [NPORTS-1:0]    ack,
    output logic [NPORTS-1:0]    ibf,
    output logic [NPORTS-1:0]    obf_n,
    output logic                 irq
);
`ifdef PPI_FIFO_EN
    localparam int FD = DEPTH;
`else
    // Single-entry latch; DEPTH only matters with the FIFO option.
    localparam int FD = DEPTH - DEPTH + 1;
`endif

    logic rd, wr, rd_q, wr_q, rd_pulse, wr_pulse;
    logic [NPORTS-1:0]         wr_data, wr_ctrl, rd_data, intr;
    logic [NPORTS-1:0][DW-1:0] rdv, stat, pout;
    logic [DW-1:0]             rd_mux;

    assign rd       = ~csn & ~rdn;
    assign wr       = ~csn & ~wrn;
    assign rd_pulse = rd & ~rd_q;
    assign wr_pulse = wr & ~wr_q;

    genvar i;
    generate
        for (i = 0; i < NPORTS; i++) begin : g_port
            assign wr_data[i] = wr_pulse & (addr[2:1] == 2'(i)) & ~addr[0];
            assign wr_ctrl[i] = wr_pulse & (addr[2:1] == 2'(i)) &  addr[0];
            assign rd_data[i] = rd_pulse & (addr[2:1] == 2'(i)) & ~addr[0];

            ppi_port #(.DW(DW), .FD(FD), .RST_DIR(RST_DIR[i])) u_port (
                .clk     (clk),
                .rst     (rst),
                .wr_data (wr_data[i]),
                .wr_ctrl (wr_ctrl[i]),
                .rd_data (rd_data[i]),
                .cpu_din (din),
                .pin_din (port_din[i*DW +: DW]),
                .stb     (stb[i]),
                .ack     (ack[i]),
                .rd_val  (rdv[i]),
                .status  (stat[i]),
                .pout    (pout[i]),
                .oe      (port_oe[i]),
                .ibf     (ibf[i]),
                .obf_n   (obf_n[i]),
                .intr    (intr[i])
            );

            assign port_dout[i*DW +: DW] = pout[i];
        end
    endgenerate

    // Unimplemented port indices fall through to all ones.
    always_comb begin
        rd_mux = '1;
        for (int p = 0; p < NPORTS; p++)
            if (addr[2:1] == 2'(p))
                rd_mux = addr[0] ? stat[p] : rdv[p];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            dout <= '1;
        end else begin
            rd_q <= rd;
            wr_q <= wr;
            if (rd_pulse)
                dout <= rd_mux;
        end
    end

    assign irq = |intr;
endmodule

// File: tb/tb_ppi_multiport.sv
// Directed bench for ppi_multiport: table of single bus ops plus handshake/FIFO sequences.

module tb_ppi_multiport;
`ifdef PPI_FIFO_EN
    localparam int FD = 4;
`else
    localparam int FD = 1;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  addr = '0;
    logic [7:0]  din = '0, dout;
    logic        rdn = 1'b1, wrn = 1'b1, csn = 1'b1;
    logic [15:0] port_din = '0, port_dout;
    logic [1:0]  port_oe, stb = '0, ack = '0, ibf, obf_n;
    logic        irq;

    int n_cmp = 0, n_err = 0;

    ppi_multiport #(.NPORTS(2), .DW(8), .DEPTH(4), .RST_DIR(2'b01)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
        .rdn(rdn), .wrn(wrn), .csn(csn), .port_din(port_din), .port_dout(port_dout),
        .port_oe(port_oe), .stb(stb), .ack(ack), .ibf(ibf), .obf_n(obf_n), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] wdata;
        logic [7:0] pin;
        logic [7:0] exp_rd;
        logic       exp_irq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; din = d; csn = 1'b0; wrn = 1'b0;
        @(negedge clk);
        csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        addr = a; csn = 1'b0; rdn = 1'b0;
        @(negedge clk);
        csn = 1'b1; rdn = 1'b1;
        v = dout;
    endtask

    task automatic stb0(input logic [7:0] d);
        @(negedge clk);
        port_din[7:0] = d; stb[0] = 1'b1;
        @(negedge clk);
        stb[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ack1();
        @(negedge clk);
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    vec_t tbl[17];
    logic [7:0] v;

    initial begin
        tbl[0]  = '{0, 3'd5, 8'h00, 8'h00, 8'hFF, 0};  // port 2 status: absent
        tbl[1]  = '{0, 3'd6, 8'h00, 8'h00, 8'hFF, 0};  // port 3 data: absent
        tbl[2]  = '{0, 3'd1, 8'h00, 8'h00, 8'h01, 0};
        tbl[3]  = '{0, 3'd3, 8'h00, 8'h00, 8'h00, 0};
        tbl[4]  = '{1, 3'd3, 8'h00, 8'h00, 8'h00, 0};
        tbl[5]  = '{1, 3'd2, 8'h3C, 8'h00, 8'h00, 0};
        tbl[6]  = '{0, 3'd2, 8'h00, 8'h00, 8'h3C, 0};
        tbl[7]  = '{0, 3'd0, 8'h00, 8'h5A, 8'h5A, 0};
        tbl[8]  = '{1, 3'd0, 8'h77, 8'h5A, 8'h00, 0};
        tbl[9]  = '{0, 3'd0, 8'h00, 8'hA5, 8'hA5, 0};
        tbl[10] = '{1, 3'd3, 8'h04, 8'h00, 8'h00, 1};
        tbl[11] = '{0, 3'd3, 8'h00, 8'h00, 8'h0C, 1};
        tbl[12] = '{0, 3'd2, 8'h00, 8'h00, 8'h3C, 1};
        tbl[13] = '{1, 3'd3, 8'h0C, 8'h00, 8'h00, 1};  // flush clears latch
        tbl[14] = '{0, 3'd2, 8'h00, 8'h00, 8'h00, 1};
        tbl[15] = '{1, 3'd3, 8'h00, 8'h00, 8'h00, 0};
        tbl[16] = '{0, 3'd3, 8'h00, 8'h00, 8'h00, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst dout", dout, 8'hFF);
        check("rst port_oe", port_oe, 2'b10);
        check("rst port_dout", port_dout, 16'h0);
        check("rst obf_n", obf_n, 2'b11);
        check("rst ibf", ibf, 2'b00);
        check("rst irq", irq, 1'b0);
        rst = 1'b0;

        // Mode 0 and address decode via table
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            port_din[7:0] = tbl[k].pin;
            if (tbl[k].wr) bus_wr(tbl[k].a, tbl[k].wdata);
            else begin
                bus_rd(tbl[k].a, v);
                check($sformatf("tbl[%0d] rd", k), v, tbl[k].exp_rd);
            end
            check($sformatf("tbl[%0d] irq", k), irq, tbl[k].exp_irq);
        end
        check("port0 latch untouched", port_dout[7:0], 8'h00);

        // Strobed output handshake on port 1
        bus_wr(3'd3, 8'h06);
        check("p1 m1 idle irq", irq, 1'b1);
        bus_wr(3'd2, 8'hA5);
        check("p1 latch", port_dout[15:8], 8'hA5);
        check("p1 obf_n wr", obf_n[1], 1'b0);
        check("p1 irq wr", irq, 1'b0);
        bus_rd(3'd3, v);
        check("p1 status pend", v, 8'h16);
        ack1();
        check("p1 obf_n ack", obf_n[1], 1'b1);
        check("p1 irq ack", irq, 1'b1);
        // ack edge and CPU write commit on the same clock: write wins
        @(negedge clk);
        ack[1] = 1'b1;
        @(negedge clk);
        addr = 3'd2; din = 8'h5A; csn = 1'b0; wrn = 1'b0;
        @(negedge clk);
        csn = 1'b1; wrn = 1'b1; ack[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("p1 ack/wr collide obf_n", obf_n[1], 1'b0);
        check("p1 ack/wr collide latch", port_dout[15:8], 8'h5A);
        ack1();
        check("p1 obf_n ack2", obf_n[1], 1'b1);
        bus_wr(3'd3, 8'h02);
        check("p1 inte off irq", irq, 1'b0);

        // Strobed input overflow on port 0
        bus_wr(3'd1, 8'h07);
        bus_rd(3'd1, v);
        check("p0 m1 status", v, 8'h27);
        for (int k = 1; k <= 5; k++) stb0(8'(k));
        bus_rd(3'd1, v);
        check("p0 full status", v, 8'h5F);
        check("p0 ibf full", ibf[0], 1'b1);
        check("p0 irq full", irq, 1'b1);
        for (int k = 1; k <= FD; k++) begin
            bus_rd(3'd0, v);
            check($sformatf("p0 drain %0d", k), v, 8'(k));
        end
        bus_rd(3'd0, v);
        check("p0 empty read", v, 8'hFF);
        check("p0 ibf drained", ibf[0], 1'b0);
        check("p0 irq drained", irq, 1'b0);
        bus_rd(3'd1, v);
        check("p0 sticky overrun", v, 8'h67);
        bus_wr(3'd1, 8'h0F);
        bus_rd(3'd1, v);
        check("p0 flush status", v, 8'h27);

        // Push coincident with pop while full
        for (int k = 0; k < FD; k++) stb0(8'h10 + 8'(k));
        @(negedge clk);
        port_din[7:0] = 8'hAA; stb[0] = 1'b1;
        @(negedge clk);
        stb[0] = 1'b0; addr = 3'd0; csn = 1'b0; rdn = 1'b0;
        @(negedge clk);
        csn = 1'b1; rdn = 1'b1;
        check("p0 coincident pop", dout, 8'h10);
        bus_rd(3'd1, v);
        check("p0 coincident status", v, 8'h1F);
        for (int k = 1; k < FD; k++) begin
            bus_rd(3'd0, v);
            check($sformatf("p0 order %0d", k), v, 8'h10 + 8'(k));
        end
        bus_rd(3'd0, v);
        check("p0 pushed tail", v, 8'hAA);
        bus_rd(3'd0, v);
        check("p0 tail empty", v, 8'hFF);

        // Flush mid-FIFO
        stb0(8'h31);
        stb0(8'h32);
        bus_wr(3'd1, 8'h0F);
        bus_rd(3'd1, v);
        check("p0 flush mid status", v, 8'h27);
        check("p0 flush ibf", ibf[0], 1'b0);
        check("p0 flush irq", irq, 1'b0);

        // Held write strobe: one write only, so ack in the middle sticks
        @(negedge clk);
        addr = 3'd2; din = 8'hC3; csn = 1'b0; wrn = 1'b0;
        @(negedge clk);
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        csn = 1'b1; wrn = 1'b1;
        @(negedge clk);
        check("held wr obf_n", obf_n[1], 1'b1);
        check("held wr latch", port_dout[15:8], 8'hC3);

        // Held read strobe: one pop only
        stb0(8'h21);
        stb0(8'h22);
        @(negedge clk);
        addr = 3'd0; csn = 1'b0; rdn = 1'b0;
        repeat (5) @(negedge clk);
        csn = 1'b1; rdn = 1'b1;
        check("held rd head", dout, 8'h21);
        bus_rd(3'd0, v);
        check("held rd next", v, (FD >= 2) ? 8'h22 : 8'hFF);

        // Reset mid-operation
        stb0(8'h41);
        bus_wr(3'd2, 8'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst ibf", ibf, 2'b00);
        check("mid rst obf_n", obf_n, 2'b11);
        check("mid rst port_oe", port_oe, 2'b10);
        check("mid rst port_dout", port_dout, 16'h0);
        check("mid rst dout", dout, 8'hFF);
        rst = 1'b0;
        bus_rd(3'd1, v);
        check("mid rst p0 status", v, 8'h01);
        bus_rd(3'd3, v);
        check("mid rst p1 status", v, 8'h00);
        check("mid rst irq", irq, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
